serial_nibble_rx: RTL and testbench
===================================

# serial_nibble_rx

Serial-to-parallel front end for the 4-bit parallel-load register stage. It watches a single-wire, UART-style serial line and deframes one start bit, WIDTH data bits (LSB first), an optional even-parity bit and one stop bit. It presents the assembled word on `data` with a one-cycle `load` strobe. `data` and `load` connect directly to the register's `I` and `load` inputs.

## Interface
- `WIDTH`, default 4: data bits per frame; must match the downstream register width.
- `BIT_CYCLES`, default 4: clk cycles per serial bit; must be even and at least 2.
- `clk`  input  1  system clock; all logic is clocked on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sin`  input  1  serial line. Idles high. Already synchronous to `clk`; the block has no synchronizer.
- `data`  output  WIDTH  last good received word; held between frames.
- `load`  output  1  one-cycle strobe; `data` is valid in the same cycle.
- `busy`  output  1  high while a frame is in progress.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.

## Operation
- Reset values: state IDLE; `data`=0, `load`=0, `busy`=0, `frame_err`=0, `parity_err`=0; bit counter and cycle counter cleared.
- States: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP, BREAK.
- IDLE: `sin`=0 in cycle c0 → START. `busy` rises at c0+1.
- START: at c0+T/2 (T = BIT_CYCLES) re-sample `sin`.
  - `sin`=1 → false start; return to IDLE with no outputs pulsed.
  - `sin`=0 → DATA.
- DATA: bit k (k=0..WIDTH-1) is sampled at c0+T/2+(k+1)·T and shifted into bit k of the shift register. After bit WIDTH-1 → PARITY, or STOP when parity is compiled out.
- PARITY: sampled one bit period after the last data bit. Even parity: XOR of the data bits and the parity bit must be 0.
- STOP: sampled one bit period after the previous sample, at cycle s.
  - Stop=1 and parity OK: `data` ← shift register and `load`=1 during cycle s+1; next state IDLE.
  - Stop=1 and parity bad: `parity_err`=1 during s+1; `data` unchanged; no `load`; next state IDLE.
  - Stop=0: `frame_err`=1 during s+1 (plus `parity_err` if parity was also bad); `data` unchanged; no `load`; next state BREAK.
- BREAK: stays here until `sin`=1, then → IDLE. A line held low is never read as a new start bit.
- `load` and the error flags are mutually exclusive and never last longer than one cycle.
- `data` changes only on a `load` cycle or on reset.

## Timing
- Frame length: (WIDTH+2+P)·T cycles, where P=1 with parity compiled in, 0 otherwise.
- Latency: `load` is high at c0+T/2+(WIDTH+1+P)·T+1.
  - Default (T=4, WIDTH=4, P=0): c0+23.
- Back-to-back frames: IDLE is re-entered in cycle s+1, so a start bit sampled in s+1 is accepted. No idle gap is needed beyond the stop bit.
- `rst` mid-frame: the partial frame is discarded. Outputs take their reset values on the next edge, and no `load` is ever issued for that frame.
- `rst` asserted in the same cycle a `load` would be issued: reset wins and `load` stays 0.

## Configuration
- `SERIAL_NIBBLE_RX_PARITY_EN` defined:
  - PARITY state is built; each frame carries one even-parity bit after the data.
  - A mismatch suppresses `load` and pulses `parity_err`.
- Not defined:
  - No PARITY state; frame is start + WIDTH data + stop.
  - `parity_err` is constant 0.

## Test plan
All scenarios use T=4, WIDTH=4 and parity compiled out unless stated.
- Reset: hold `rst`=1 for 2 cycles with `sin`=1 → all outputs 0, `busy`=0.
- Good frame, 0xA: send start, data bits 0,1,0,1 (LSB first), stop 1 → `load` is a single-cycle pulse at c0+23 with `data`=4'b1010. `busy` is high from c0+1 through the last STOP cycle.
- False start: pulse `sin` low for 1 cycle only → no `load`, no flags, back in IDLE. A following good 0xF frame loads `data`=4'b1111.
- Framing error: send 0x3 with stop=0 → `frame_err` pulse, `data` keeps its prior value. Hold `sin` low for 10 more cycles → no new frame. Raise `sin`, then send 0x5 → `load` with `data`=4'b0101.
- Back-to-back: send 0x3 then 0xC with no idle gap → two `load` pulses 24 cycles apart; `data` reads 0x3, then 0xC.
- Parity (macro defined): 0x7 with parity bit 1 → `load`, `data`=4'b0111. 0x7 with parity bit 0 → `parity_err` pulse, no `load`. Assert `rst` during bit 2 of the next frame → no `load`, outputs return to 0.

Source files
------------

// File: rtl/serial_nibble_rx.sv
// serial_nibble_rx: UART-style deframer feeding a WIDTH-bit parallel-load register.
// Optional even-parity bit built when SERIAL_NIBBLE_RX_PARITY_EN is defined.
module serial_nibble_rx #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bitn;
  logic [WIDTH-1:0] shreg;

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic             perr;
`else
  assign parity_err = 1'b0;
`endif

  // Frame FSM: mid-bit sampling, word assembly and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      data      <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      perr       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!sin) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (sin) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              bitn  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt         <= '0;
            shreg[bitn] <= sin;
            if (bitn == LAST) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bitn <= bitn + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            perr  <= (^shreg) ^ sin;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL) begin
            cnt  <= '0;
            busy <= 1'b0;
            if (sin) begin
              state <= IDLE;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
              if (perr) begin
                parity_err <= 1'b1;
              end else begin
                load <= 1'b1;
                data <= shreg;
              end
`else
              load <= 1'b1;
              data <= shreg;
`endif
            end else begin
              state     <= BREAK;
              frame_err <= 1'b1;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
              parity_err <= perr;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (sin) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// tb_serial_nibble_rx: directed plus random frames against a frame-level model.
// Define SERIAL_NIBBLE_RX_PARITY_EN for both bench and DUT to cover parity.
module tb_serial_nibble_rx;

  localparam int W = 4;
  localparam int T = 4;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB  = W + 2 + P;
  localparam int LAT = T / 2 + (W + 1 + P) * T + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b1;
  logic [W-1:0] data;
  logic         load;
  logic         busy;
  logic         frame_err;
  logic         parity_err;

  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_data = '0;

  typedef struct {
    int           c;
    logic         ld;
    logic         fe;
    logic         pe;
    logic [W-1:0] d;
  } ev_t;

  ev_t evq[$];

  serial_nibble_rx #(
    .WIDTH(W),
    .BIT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sin(sin),
    .data(data),
    .load(load),
    .busy(busy),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // log every strobe with the cycle it is visible in
  always @(negedge clk) begin
    if (load | frame_err | parity_err) begin
      evq.push_back('{cyc, load, frame_err, parity_err, data});
      chk("excl", {31'd0, load & (frame_err | parity_err)}, 32'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic pb,
                      input logic stp, input int rst_at,
                      output int c0);
    logic [NB-1:0] fb;
    fb[0] = 1'b0;
    for (int k = 0; k < W; k++) fb[1+k] = d[k];
    if (P == 1) fb[W+1] = pb;
    fb[NB-1] = stp;
    c0 = cyc;
    for (int j = 0; j < NB; j++) begin
      for (int t = 0; t < T; t++) begin
        int i;
        i = j * T + t;
        sin = fb[j];
        rst = (i == rst_at);
        if (rst_at < 0) begin
          if (i == 0)       chk("busy_c0", {31'd0, busy}, 32'd0);
          if (i == 1)       chk("busy_c1", {31'd0, busy}, 32'd1);
          if (i == LAT - 1) chk("busy_s", {31'd0, busy}, 32'd1);
          if (i == LAT)     chk("busy_s1", {31'd0, busy}, 32'd0);
        end
        tick;
      end
    end
    rst = 1'b0;
  endtask

  task automatic expect_frame(input int c0, input logic [W-1:0] d,
                              input logic pb, input logic stp);
    logic perr;
    logic ok;
    ev_t  e;
    perr = (P == 1) ? ((^d) ^ pb) : 1'b0;
    ok   = stp & ~perr;
    chk("nevents", evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk("ev_cycle", e.c, c0 + LAT);
      chk("ev_load", {31'd0, e.ld}, {31'd0, ok});
      chk("ev_ferr", {31'd0, e.fe}, {31'd0, ~stp});
      chk("ev_perr", {31'd0, e.pe}, {31'd0, perr});
      if (ok) begin
        exp_data = d;
        chk("ev_data", {28'd0, e.d}, {28'd0, d});
      end
    end
    evq.delete();
    chk("data", {28'd0, data}, {28'd0, exp_data});
  endtask

  initial begin
    int           c0;
    logic         prev_stp;
    logic [W-1:0] d;
    logic         pb;
    logic         stp;

    rst = 1'b1;
    sin = 1'b1;
    tick;
    tick;
    chk("rst_data", {28'd0, data}, 32'd0);
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    rst = 1'b0;
    tick;
    evq.delete();

    send(4'hA, ^4'hA, 1'b1, -1, c0);
    expect_frame(c0, 4'hA, ^4'hA, 1'b1);

    sin = 1'b0;
    tick;
    sin = 1'b1;
    repeat (2 * T) tick;
    chk("false_ev", evq.size(), 0);
    chk("false_busy", {31'd0, busy}, 32'd0);

    send(4'hF, ^4'hF, 1'b1, -1, c0);
    expect_frame(c0, 4'hF, ^4'hF, 1'b1);

    send(4'h3, ^4'h3, 1'b0, -1, c0);
    expect_frame(c0, 4'h3, ^4'h3, 1'b0);
    repeat (10) tick;
    chk("break_ev", evq.size(), 0);
    sin = 1'b1;
    tick;
    tick;
    send(4'h5, ^4'h5, 1'b1, -1, c0);
    expect_frame(c0, 4'h5, ^4'h5, 1'b1);

    send(4'h3, ^4'h3, 1'b1, -1, c0);
    expect_frame(c0, 4'h3, ^4'h3, 1'b1);
    send(4'hC, ^4'hC, 1'b1, -1, c0);
    expect_frame(c0, 4'hC, ^4'hC, 1'b1);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    send(4'h7, 1'b1, 1'b1, -1, c0);
    expect_frame(c0, 4'h7, 1'b1, 1'b1);
    send(4'h7, 1'b0, 1'b1, -1, c0);
    expect_frame(c0, 4'h7, 1'b0, 1'b1);
`endif

    send(4'hF, 1'b1, 1'b1, 3 * T + 1, c0);
    repeat (4) tick;
    exp_data = '0;
    chk("midrst_ev", evq.size(), 0);
    chk("midrst_data", {28'd0, data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    evq.delete();

    send(4'h9, ^4'h9, 1'b1, -1, c0);
    expect_frame(c0, 4'h9, ^4'h9, 1'b1);
    send(4'h6, ^4'h6, 1'b1, LAT - 1, c0);
    exp_data = '0;
    chk("rstwin_ev", evq.size(), 0);
    chk("rstwin_data", {28'd0, data}, 32'd0);
    evq.delete();

    prev_stp = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (!prev_stp || $urandom_range(0, 1) == 1) begin
        sin = 1'b1;
        repeat ($urandom_range(1, 3)) tick;
      end
      d   = W'($urandom);
      pb  = (^d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 5) != 0);
      send(d, pb, stp, -1, c0);
      expect_frame(c0, d, pb, stp);
      prev_stp = stp;
    end

    sin = 1'b1;
    repeat (6) tick;
    chk("tail_ev", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
